// File: rtl/lcd_mem_pkg.sv
// lcd_mem_pkg: definitions shared by the output-RAM result reader.
//   - MODE_*        : source-selection encodings sampled on start
//   - bank_e        : bank encoding carried on m_src
//   - EN_CE / EN_WE : bit positions inside the 2-bit RAM enable words
//   - rr_state_e    : result-reader FSM states
//   - rr_tag_t      : side-band tag stored next to each buffered word
package lcd_mem_pkg;

  localparam logic [1:0] MODE_S   = 2'b00;
  localparam logic [1:0] MODE_P1  = 2'b01;
  localparam logic [1:0] MODE_P2  = 2'b10;
  localparam logic [1:0] MODE_ALL = 2'b11;

  typedef enum logic [1:0] {
    BANK_S  = 2'b00,
    BANK_P1 = 2'b01,
    BANK_P2 = 2'b10
  } bank_e;

  localparam int EN_CE = 1;
  localparam int EN_WE = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } rr_state_e;

  typedef struct packed {
    logic [1:0] src;
    logic       last;
  } rr_tag_t;

  // Bank visited at position idx of the drain list for a given mode.
  function automatic logic [1:0] bank_for(input logic [1:0] mode, input logic [1:0] idx);
    if (mode == MODE_ALL) begin
      return idx;
    end else begin
      return mode;
    end
  endfunction

  // Index of the final bank in the drain list.
  function automatic logic [1:0] last_bank_idx(input logic [1:0] mode);
    if (mode == MODE_ALL) begin
      return 2'd2;
    end else begin
      return 2'd0;
    end
  endfunction

  // One-hot chip-enable vector {P2, P1, S} for a bank code.
  function automatic logic [2:0] bank_onehot(input logic [1:0] bank);
    case (bank)
      BANK_S:  return 3'b001;
      BANK_P1: return 3'b010;
      BANK_P2: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // RAM enable word for a read-only port: write enable is never set.
  function automatic logic [1:0] en_word(input logic ce);
    logic [1:0] w;
    w        = 2'b00;
    w[EN_CE] = ce;
    w[EN_WE] = 1'b0;
    return w;
  endfunction

endpackage

// File: rtl/rr_fifo2.sv
// rr_fifo2: 2-entry shift FIFO for result words plus {src, last} tags.
// The head entry is always register 0, so the outputs come straight from
// flops and never glitch while a word is waiting for the consumer.
//   clk, rst (async, active-low)
//   push / in_*    : write side; ignored when full unless popping too
//   pop  / out_*   : read side; out_* is the oldest entry
//   full, empty, count : occupancy status
module rr_fifo2
  import lcd_mem_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_src,
  input  logic              in_last,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_src,
  output logic              out_last,
  output logic              full,
  output logic              empty,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] head_data_r;
  logic [DATA_W-1:0] tail_data_r;
  rr_tag_t           head_tag_r;
  rr_tag_t           tail_tag_r;
  rr_tag_t           in_tag_s;
  logic [1:0]        count_r;
  logic              do_push_s;
  logic              do_pop_s;

  // Qualify push/pop against occupancy; push on full is legal only with a pop.
  always_comb begin
    in_tag_s.src  = in_src;
    in_tag_s.last = in_last;
    do_pop_s      = pop && (count_r != 2'd0);
    do_push_s     = push && ((count_r != 2'd2) || do_pop_s);
  end

  // Storage and occupancy update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_data_r <= {DATA_W{1'b0}};
      tail_data_r <= {DATA_W{1'b0}};
      head_tag_r  <= '{src: 2'b00, last: 1'b0};
      tail_tag_r  <= '{src: 2'b00, last: 1'b0};
      count_r     <= 2'd0;
    end else begin
      case (count_r)
        2'd0: begin
          if (do_push_s) begin
            head_data_r <= in_data;
            head_tag_r  <= in_tag_s;
            count_r     <= 2'd1;
          end
        end
        2'd1: begin
          if (do_push_s && do_pop_s) begin
            head_data_r <= in_data;
            head_tag_r  <= in_tag_s;
          end else if (do_push_s) begin
            tail_data_r <= in_data;
            tail_tag_r  <= in_tag_s;
            count_r     <= 2'd2;
          end else if (do_pop_s) begin
            count_r     <= 2'd0;
          end
        end
        2'd2: begin
          if (do_pop_s) begin
            head_data_r <= tail_data_r;
            head_tag_r  <= tail_tag_r;
            if (do_push_s) begin
              tail_data_r <= in_data;
              tail_tag_r  <= in_tag_s;
            end else begin
              count_r     <= 2'd1;
            end
          end
        end
        default: count_r <= 2'd0;
      endcase
    end
  end

  assign out_data = head_data_r;
  assign out_src  = head_tag_r.src;
  assign out_last = head_tag_r.last;
  assign full     = (count_r == 2'd2);
  assign empty    = (count_r == 2'd0);
  assign count    = count_r;

endmodule

// File: rtl/result_reader.sv
// result_reader: drains the S / P1 / P2 output RAMs and streams the words
// over a valid/ready port.
//   clk, rst (async, active-low)
//   start, mode_sel       : drain request and bank selection (00 S, 01 P1, 10 P2, 11 all)
//   busy, done            : drain in progress / one-cycle completion pulse
//   en_S, en_P1, en_P2    : {ce, we} per RAM, we always 0
//   addr_rd               : shared read address
//   rd_S, rd_P1, rd_P2    : RAM read data, valid in the cycle ce is asserted
//   m_data, m_valid, m_ready, m_last, m_src : output stream
// A read issued in one cycle lands in the FIFO on the closing edge, so
// the FIFO occupancy after that edge plus the next read must not exceed 2.
module result_reader #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode_sel,
  output logic              busy,
  output logic              done,
  output logic [1:0]        en_S,
  output logic [1:0]        en_P1,
  output logic [1:0]        en_P2,
  output logic [ADDR_W-1:0] addr_rd,
  input  logic [DATA_W-1:0] rd_S,
  input  logic [DATA_W-1:0] rd_P1,
  input  logic [DATA_W-1:0] rd_P2,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic [1:0]        m_src
);

  import lcd_mem_pkg::*;

  rr_state_e         state_r;
  logic [1:0]        mode_r;
  logic [1:0]        nxt_idx_r;
  logic [ADDR_W-1:0] nxt_addr_r;
  logic [2:0]        ce_r;
  logic [ADDR_W-1:0] addr_rd_r;
  logic [1:0]        cur_bank_r;
  logic              cur_last_r;
  logic              busy_r;
  logic              done_r;

  logic [DATA_W-1:0] push_data_s;
  logic              push_s;
  logic              pop_s;
  logic              fifo_push_s;
  logic [2:0]        next_occ_s;
  logic              credit_s;
  logic              last_issue_s;
  logic [1:0]        issue_bank_s;
  logic [1:0]        start_bank_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              fifo_last_s;
  logic [1:0]        fifo_count_s;

  // Capture mux, credit check and next-read selection.
  always_comb begin
    case (cur_bank_r)
      BANK_S:  push_data_s = rd_S;
      BANK_P1: push_data_s = rd_P1;
      BANK_P2: push_data_s = rd_P2;
      default: push_data_s = rd_S;
    endcase
    push_s       = |ce_r;
    pop_s        = !fifo_empty_s && m_ready;
    fifo_push_s  = push_s && (!fifo_full_s || pop_s);
    next_occ_s   = {1'b0, fifo_count_s} + {2'b00, push_s} - {2'b00, pop_s};
    credit_s     = (next_occ_s < 3'd2);
    issue_bank_s = bank_for(mode_r, nxt_idx_r);
    start_bank_s = bank_for(mode_sel, 2'd0);
    last_issue_s = (nxt_addr_r == ADDR_W'(DEPTH - 1)) &&
                   (nxt_idx_r == last_bank_idx(mode_r));
  end

  // Drain FSM; the first read is launched on the accepting edge itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      mode_r     <= MODE_S;
      nxt_idx_r  <= 2'd0;
      nxt_addr_r <= {ADDR_W{1'b0}};
      ce_r       <= 3'b000;
      addr_rd_r  <= {ADDR_W{1'b0}};
      cur_bank_r <= 2'b00;
      cur_last_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          ce_r <= 3'b000;
          if (start) begin
            state_r    <= ST_READ;
            busy_r     <= 1'b1;
            mode_r     <= mode_sel;
            ce_r       <= bank_onehot(start_bank_s);
            addr_rd_r  <= {ADDR_W{1'b0}};
            cur_bank_r <= start_bank_s;
            cur_last_r <= 1'b0;
            nxt_idx_r  <= 2'd0;
            nxt_addr_r <= ADDR_W'(1);
          end
        end
        ST_READ: begin
          if (credit_s) begin
            ce_r       <= bank_onehot(issue_bank_s);
            addr_rd_r  <= nxt_addr_r;
            cur_bank_r <= issue_bank_s;
            cur_last_r <= last_issue_s;
            if (nxt_addr_r == ADDR_W'(DEPTH - 1)) begin
              nxt_addr_r <= {ADDR_W{1'b0}};
              nxt_idx_r  <= nxt_idx_r + 2'd1;
            end else begin
              nxt_addr_r <= nxt_addr_r + ADDR_W'(1);
            end
            if (last_issue_s) begin
              state_r <= ST_DRAIN;
            end
          end else begin
            ce_r <= 3'b000;
          end
        end
        ST_DRAIN: begin
          ce_r <= 3'b000;
          // The tagged last word leaving the FIFO means nothing remains.
          if (pop_s && fifo_last_s) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end
        end
        ST_DONE: begin
          ce_r    <= 3'b000;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          ce_r    <= 3'b000;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  rr_fifo2 #(.DATA_W(DATA_W)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push_s),
    .pop      (pop_s),
    .in_data  (push_data_s),
    .in_src   (cur_bank_r),
    .in_last  (cur_last_r),
    .out_data (m_data),
    .out_src  (m_src),
    .out_last (fifo_last_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s),
    .count    (fifo_count_s)
  );

  assign m_valid = !fifo_empty_s;
  assign m_last  = fifo_last_s;
  assign busy    = busy_r;
  assign done    = done_r;
  assign addr_rd = addr_rd_r;
  assign en_S    = en_word(ce_r[0]);
  assign en_P1   = en_word(ce_r[1]);
  assign en_P2   = en_word(ce_r[2]);

endmodule

// File: tb/tb_result_reader.sv
module tb_result_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] mode_sel;
  logic       m_ready;
  logic       busy, done, m_valid, m_last;
  logic [1:0] en_S, en_P1, en_P2, m_src;
  logic [1:0] addr_rd;
  logic [7:0] rd_S, rd_P1, rd_P2, m_data;

  logic [7:0] mem_s [4];
  logic [7:0] mem_p1[4];
  logic [7:0] mem_p2[4];

  logic [7:0] exp_d[12];
  logic [1:0] exp_s[12];

  int checks = 0;
  int errors = 0;
  int d_done_cyc, d_first_valid, d_issued20;
  logic [7:0] d_data20;
  logic       d_valid20;

  always #5 clk = ~clk;

  // Combinational-read RAM models; a non-enabled port returns a marker value.
  assign rd_S  = en_S[1]  ? mem_s[addr_rd]  : 8'hEE;
  assign rd_P1 = en_P1[1] ? mem_p1[addr_rd] : 8'hEE;
  assign rd_P2 = en_P2[1] ? mem_p2[addr_rd] : 8'hEE;

  result_reader #(.DATA_W(8), .DEPTH(4), .ADDR_W(2)) dut (
    .clk(clk), .rst(rst), .start(start), .mode_sel(mode_sel),
    .busy(busy), .done(done), .en_S(en_S), .en_P1(en_P1), .en_P2(en_P2),
    .addr_rd(addr_rd), .rd_S(rd_S), .rd_P1(rd_P1), .rd_P2(rd_P2),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .m_src(m_src)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic ready_for(input int pat, input int c);
    if (pat == 1) return ((c % 4) == 1) || ((c % 4) == 0);
    if (pat == 2) return (c > 20);
    return 1'b1;
  endfunction

  task automatic start_drain(input logic [1:0] mode);
    start    = 1'b1;
    mode_sel = mode;
    tick();
    start    = 1'b0;
  endtask

  task automatic load_exp(input logic [7:0] base, input logic [1:0] src, input int first);
    for (int i = 0; i < 4; i++) begin
      exp_d[first + i] = base + 8'(i);
      exp_s[first + i] = src;
    end
  endtask

  // Follows one drain from the cycle after start; cycle c counts from start.
  task automatic drain(input int n, input int pat, input int inj);
    int issued = 0;
    int xfers = 0;
    int lasts = 0;
    int max_out = 0;
    logic finished = 1'b0;
    logic stall = 1'b0;
    logic [7:0] held_d = 8'h00;
    logic [1:0] held_s = 2'b00;
    d_done_cyc = -1;
    d_first_valid = -1;
    d_issued20 = -1;
    for (int c = 1; c <= 100 && !finished; c++) begin
      m_ready = ready_for(pat, c);
      if (inj > 0 && c == inj) begin
        start    = 1'b1;
        mode_sel = 2'b10;
      end else begin
        start = 1'b0;
      end
      if (en_S[1] || en_P1[1] || en_P2[1]) issued++;
      if (issued - xfers > max_out) max_out = issued - xfers;
      if (c == 20) begin
        d_issued20 = issued;
        d_data20   = m_data;
        d_valid20  = m_valid;
      end
      if (stall) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, held_d);
        chk("stall_src", m_src, held_s);
      end
      if (m_valid && d_first_valid < 0) d_first_valid = c;
      if (done) begin
        d_done_cyc = c;
        finished = 1'b1;
        chk("valid_at_done", m_valid, 0);
      end else if (m_valid && m_ready) begin
        if (xfers < n) begin
          chk("word_data", m_data, exp_d[xfers]);
          chk("word_src", m_src, exp_s[xfers]);
          chk("word_last", m_last, (xfers == n - 1));
        end else begin
          chk("extra_word", xfers, n - 1);
        end
        if (m_last) lasts++;
        xfers++;
      end
      stall  = m_valid && !m_ready;
      held_d = m_data;
      held_s = m_src;
      if (!finished) tick();
    end
    start   = 1'b0;
    m_ready = 1'b1;
    chk("drain_finished", finished, 1);
    chk("word_count", xfers, n);
    chk("last_count", lasts, 1);
    chk("max_outstanding_le2", (max_out <= 2), 1);
  endtask

  task automatic check_idle_after_done();
    tick();
    chk("done_pulse_1cyc", done, 0);
    chk("busy_after_done", busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_valid"}, m_valid, 0);
    chk({tag, "_last"}, m_last, 0);
    chk({tag, "_data"}, m_data, 0);
    chk({tag, "_src"}, m_src, 0);
    chk({tag, "_en"}, {en_S, en_P1, en_P2}, 0);
    chk({tag, "_addr"}, addr_rd, 0);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    mode_sel = 2'b00;
    m_ready = 1'b1;
    mem_s  = '{8'h11, 8'h22, 8'h33, 8'h44};
    mem_p1 = '{8'h20, 8'h21, 8'h22, 8'h23};
    mem_p2 = '{8'h30, 8'h31, 8'h32, 8'h33};

    // Reset state
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b1;
    tick();

    // Mode 00, m_ready high: latency and throughput
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_s = '{default: 2'b00};
    start_drain(2'b00);
    chk("t1_first_ce", en_S, 2'b10);
    chk("t1_other_ce", {en_P1, en_P2}, 4'b0000);
    chk("t1_first_addr", addr_rd, 0);
    chk("t1_busy", busy, 1);
    chk("t1_no_early_valid", m_valid, 0);
    drain(4, 0, 0);
    chk("t1_first_valid_cyc", d_first_valid, 2);
    chk("t1_done_cyc", d_done_cyc, 6);
    check_idle_after_done();

    // Second start mid-drain with mode 10 is ignored
    start_drain(2'b00);
    drain(4, 0, 3);
    chk("t4_done_cyc", d_done_cyc, 6);
    check_idle_after_done();
    chk("t4_no_restart_ce", {en_S, en_P1, en_P2}, 6'b000000);

    // Mode 11: S, P1, P2 in order
    mem_s = '{8'h10, 8'h11, 8'h12, 8'h13};
    load_exp(8'h10, 2'b00, 0);
    load_exp(8'h20, 2'b01, 4);
    load_exp(8'h30, 2'b10, 8);
    start_drain(2'b11);
    drain(12, 0, 0);
    chk("t2_done_cyc", d_done_cyc, 14);
    check_idle_after_done();

    // Mode 01 with m_ready toggling 1,0,0,1
    load_exp(8'h20, 2'b01, 0);
    start_drain(2'b01);
    drain(4, 1, 0);
    check_idle_after_done();

    // Reset during the third word of mode 11, then a clean mode 10 drain
    start_drain(2'b11);
    tick();
    tick();
    tick();
    chk("t5_third_word", m_data, 8'h12);
    chk("t5_addr_before_rst", addr_rd, 3);
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    tick();
    tick();
    chk("t5_no_done_in_rst", done, 0);
    rst = 1'b1;
    tick();
    chk("t5_idle_after_rst", busy, 0);
    chk("t5_no_done_after_rst", done, 0);
    load_exp(8'h30, 2'b10, 0);
    start_drain(2'b10);
    drain(4, 0, 0);
    chk("t5_done_cyc", d_done_cyc, 6);
    check_idle_after_done();

    // m_ready low for 20 cycles after start
    start_drain(2'b10);
    drain(4, 2, 0);
    chk("t6_reads_while_stalled", d_issued20, 2);
    chk("t6_valid_held", d_valid20, 1);
    chk("t6_first_word_held", d_data20, 8'h30);
    chk("t6_done_cyc", d_done_cyc, 25);
    check_idle_after_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/result_reader.md
# result_reader

Drains convolution results from the three 4-entry output RAMs (serial, parallel-1, parallel-2) of the main memory module and streams them out as 8-bit words over a valid/ready interface. It is the read-side counterpart to the engines that write those RAMs. It sits between the memory module's `out_S0`/`out_P1_0`/`out_P2_0` read ports and the host/display path. It generates read addresses and chip enables, absorbs the RAM read latency, and honours downstream back-pressure without dropping or duplicating words.

## Interface
Parameters:
- `DATA_W`, default 8: result word width.
- `DEPTH`, default 4: entries per output RAM.
- `ADDR_W`, default 2: RAM address width, equal to log2(`DEPTH`).

Ports:
- `clk`, in, 1: single clock for the block.
- `rst`, in, 1: reset. Asynchronous and active-low.
- `start`, in, 1: one-cycle request to begin a drain. Ignored while `busy`.
- `mode_sel`, in, 2: source selection, sampled on `start`. 00 = S, 01 = P1, 10 = P2, 11 = S then P1 then P2.
- `busy`, out, 1: high from the cycle after an accepted `start` until `done`.
- `done`, out, 1: one-cycle pulse after the last word is accepted downstream.
- `en_S`, `en_P1`, `en_P2`, out, 2 each: RAM enables. Bit 1 is ce, bit 0 is we. we is always 0.
- `addr_rd`, out, `ADDR_W`: read address, wired to port 0 of all three output RAMs.
- `rd_S`, `rd_P1`, `rd_P2`, in, `DATA_W` each: RAM port-0 read data.
- `m_data`, out, `DATA_W`: output word.
- `m_valid`, out, 1: `m_data` is valid.
- `m_ready`, in, 1: downstream accepts the word.
- `m_last`, out, 1: marks the final word of the drain.
- `m_src`, out, 2: bank of the current word. 00 = S, 01 = P1, 10 = P2.

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE → READ when `start` is high. On that edge the block latches the bank list from `mode_sel`, clears `addr_rd` to 0 and sets the bank index to the first bank.
  - READ issues one read per cycle whenever credit is available (credit rule below). Each issue asserts ce on the current bank only and drives `addr_rd`.
  - After a read issues at address `DEPTH-1`, `addr_rd` wraps to 0 and the bank index advances.
  - READ → DRAIN after the final read issues: address `DEPTH-1` of the last bank.
  - DRAIN → DONE when the buffer is empty and the last word has been accepted.
  - DONE → IDLE unconditionally after 1 cycle, with `done` = 1 during that cycle.
- Credit rule: a read issues only if buffer occupancy plus in-flight reads is less than 2. This guarantees no overflow.
- Read data is captured 1 cycle after ce, from the bank selected for that read. It is pushed into the 2-entry buffer together with its `m_src` and `m_last` tags.
- `m_last` = 1 only on word `DEPTH-1` of the last bank.
- A word transfers on a cycle with `m_valid` and `m_ready` both high. Once asserted, `m_valid` and its `m_data`/`m_src`/`m_last` stay stable until the transfer.
- A simultaneous push and pop on a full buffer is legal. Occupancy is unchanged.
- `start` while `busy` has no effect. `mode_sel` changes mid-drain have no effect.
- Word count per drain: 4 for modes 00, 01 and 10; 12 for mode 11.

## Timing
- Reset values while `rst` is low, regardless of clock: `busy`=0, `done`=0, `m_valid`=0, `m_last`=0, `m_data`=0, `m_src`=0, all `en_*`=00, `addr_rd`=0. FSM is in IDLE, buffer is empty.
- Reset asserted mid-drain: in-flight and buffered words are discarded and no `done` pulse is produced.
- `start` in cycle T:
  - First ce asserts in T+1.
  - First `m_valid` asserts in T+2.
- With `m_ready` held high: one word per cycle, so mode 00 ends with the last transfer in T+5 and `done` in T+6.
- Worst-case ce gap after a stall releases: 1 cycle.

## Structure
- Shared package `lcd_mem_pkg` holds:
  - The mode encoding constants (`MODE_S`, `MODE_P1`, `MODE_P2`, `MODE_ALL`).
  - The bank encoding used by `m_src`.
  - The `en` bit positions (ce = 1, we = 0).
  - The FSM state enum.
- One sub-module: `rr_fifo2`, a 2-entry FIFO of {data, src, last} with push, pop, full, empty and count outputs.

## Test plan
- Mode 00, RAM S preloaded 0x11, 0x22, 0x33, 0x44, `m_ready`=1 → words 11, 22, 33, 44 with `m_src`=00, `m_last` only on 44, `done` at T+6.
- Mode 11, S/P1/P2 preloaded 0x10–0x13, 0x20–0x23 and 0x30–0x33 → 12 words in order, `m_src` switches 00→01→10, one `m_last`, one `done`.
- Mode 01 with `m_ready` toggling 1,0,0,1 repeatedly → the P1 sequence is delivered intact, there are never more than 2 reads outstanding, and data stays stable while stalled.
- `start` pulsed again mid-drain with `mode_sel`=10 → ignored, and the original 4 words complete.
- `rst` low during the third word of mode 11 → all outputs read 0 immediately. A new `start` in mode 10 then drains P2 normally.
- `m_ready`=0 for 20 cycles after `start` → exactly 2 reads issue, `m_valid` is held with the first word, and the remaining reads resume when `m_ready` rises.
